// File: rtl/serial_cmp_pkg.sv
// Shared types for serial-datapath controllers: controller state encoding,
// comparator verdict struct and a width helper.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } sc_state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

  // Index width that never collapses to zero bits (N=1 still needs a 1-bit id).
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping.
// Purely combinational; the owner keeps ptr and updates it to the grant.
module rr_arbiter
  import serial_cmp_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             gnt_vld
);

  // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the first set request wins, so the
  // previous winner is considered last.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (en && !gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/serial_cmp.sv
// MSB-first serial magnitude comparator. The first differing bit decides the
// verdict; all later bits are ignored. The verdict output already accounts
// for the bit on a/b this cycle, so a controller can capture the final
// answer on the same edge that consumes the last bit.
module serial_cmp
  import serial_cmp_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        en,
  input  logic        a,
  input  logic        b,
  output cmp_result_t res
);

  typedef enum logic [1:0] {
    C_EQ = 2'd0,
    C_LT = 2'd1,
    C_GT = 2'd2
  } cst_e;

  cst_e st;

  // Lock on the first differing bit; stays locked until the next srst.
  always_ff @(posedge clk) begin
    if (srst)                       st <= C_EQ;
    else if (en && st == C_EQ && a != b) st <= a ? C_GT : C_LT;
  end

  // Look-ahead verdict: locked state, or the current bit when still equal.
  always_comb begin
    res = '0;
    unique case (st)
      C_LT:    res.lt = 1'b1;
      C_GT:    res.gt = 1'b1;
      default: begin
        if (!en || a == b) res.eq = 1'b1;
        else if (a)        res.gt = 1'b1;
        else               res.lt = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/serial_compare_scheduler.sv
// Shares one serial comparator among N_REQ requesters. A round-robin grant
// accepts one operand pair in IDLE, the pair is shifted MSB first for WIDTH
// cycles, and the lt/eq/gt verdict is held on a response handshake tagged
// with the requester index.
module serial_compare_scheduler
  import serial_cmp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = clog2_min1(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_lt,
  output logic                   rsp_eq,
  output logic                   rsp_gt,
  output logic                   busy
);

  localparam int CNT_W = clog2_min1(WIDTH);

  sc_state_e                     state;
  logic [ID_W-1:0]               ptr;
  logic [ID_W-1:0]               id_q;
  logic [CNT_W-1:0]              cnt;
  logic [WIDTH-1:0]              a_q;
  logic [WIDTH-1:0]              b_q;
  logic [N_REQ-1:0][WIDTH-1:0]   a_arr;
  logic [N_REQ-1:0][WIDTH-1:0]   b_arr;
  logic [N_REQ-1:0]              gnt;
  logic [ID_W-1:0]               g_idx;
  logic                          g_vld;
  logic                          arb_en;
  logic                          accept;
  logic                          cmp_rst;
  logic                          cmp_en;
  cmp_result_t                   cmp_res;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Grants only in IDLE and never while reset is asserted, so req_ready is
  // low throughout reset even though IDLE is the reset state.
  assign arb_en    = (state == IDLE) && rst;
  assign req_ready = gnt;
  assign accept    = g_vld;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_valid),
    .en      (arb_en),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (g_idx),
    .gnt_vld (g_vld)
  );

  // Comparator is cleared during reset and on every accept, so each
  // transaction starts from "equal so far".
  assign cmp_rst = ~rst | accept;
  assign cmp_en  = (state == SHIFT);

  serial_cmp u_cmp (
    .clk  (clk),
    .srst (cmp_rst),
    .en   (cmp_en),
    .a    (a_q[cnt]),
    .b    (b_q[cnt]),
    .res  (cmp_res)
  );

  // Controller FSM: accept -> shift WIDTH bits -> hold verdict until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= ID_W'(N_REQ - 1);
      id_q      <= '0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_gt    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= a_arr[g_idx];
            b_q   <= b_arr[g_idx];
            id_q  <= g_idx;
            ptr   <= g_idx;
            cnt   <= CNT_W'(WIDTH - 1);
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          // Last bit: the look-ahead verdict already includes bit 0.
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_lt    <= cmp_res.lt;
            rsp_eq    <= cmp_res.eq;
            rsp_gt    <= cmp_res.gt;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
